// File: rtl/keyboard_state_decoder_pkg.sv
// keyboard_state_decoder_pkg: shared PS/2 Set-2 constants, FSM states and key indices
// Contents: prefix bytes (E0/F0/E1), control codes (AA/FA/FC/FE, overrun 00/FF),
// decoder FSM encoding, key-index constants and the default key-vector width.
package keyboard_state_decoder_pkg;
  localparam int NUM_KEYS_DEFAULT = 32;
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_FC = 8'hFC;
  localparam logic [7:0] SC_FE = 8'hFE;
  localparam logic [7:0] SC_OVR_LO = 8'h00;
  localparam logic [7:0] SC_OVR_HI = 8'hFF;
  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} kbd_state_e;
  localparam int KEY_SPACE = 0;
  localparam int KEY_ENTER = 1;
  localparam int KEY_R     = 2;
  localparam int KEY_A     = 3;
  localparam int KEY_S     = 4;
  localparam int KEY_D     = 5;
  localparam int KEY_F     = 6;
  localparam int KEY_G     = 7;
  localparam int KEY_H     = 8;
  localparam int KEY_J     = 9;
  localparam int KEY_K     = 10;
  localparam int KEY_W     = 11;
  localparam int KEY_E     = 12;
  localparam int KEY_T     = 13;
  localparam int KEY_Y     = 14;
  localparam int KEY_U     = 15;
  localparam int KEY_UP    = 16;
  localparam int KEY_DOWN  = 17;
  localparam int KEY_LEFT  = 18;
  localparam int KEY_RIGHT = 19;
  // BAT result or buffer overrun: the keyboard's view of held keys is lost
  function automatic logic is_clear_code(input logic [7:0] b);
    return b == SC_AA || b == SC_FC || b == SC_OVR_LO || b == SC_OVR_HI;
  endfunction
endpackage

// File: rtl/keyboard_state_decoder_scancode_lut.sv
// keyboard_state_decoder_scancode_lut: {ext, code} -> (hit, key index) lookup
// Ports: key[8:0] = {E0-extended flag, Set-2 code}; hit = key is mapped;
// index = bit position in the key-state vector (valid only when hit).
module keyboard_state_decoder_scancode_lut
  import keyboard_state_decoder_pkg::*;
#(
  parameter int NUM_KEYS = NUM_KEYS_DEFAULT,
  localparam int IW = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1
) (
  input  logic [8:0]    key,
  output logic          hit,
  output logic [IW-1:0] index
);
  int idx;
  always_comb begin
    idx = -1;
    case (key)
      9'h029: idx = KEY_SPACE;
      9'h05A: idx = KEY_ENTER;
      9'h02D: idx = KEY_R;
      9'h01C: idx = KEY_A;
      9'h01B: idx = KEY_S;
      9'h023: idx = KEY_D;
      9'h02B: idx = KEY_F;
      9'h034: idx = KEY_G;
      9'h033: idx = KEY_H;
      9'h03B: idx = KEY_J;
      9'h042: idx = KEY_K;
      9'h01D: idx = KEY_W;
      9'h024: idx = KEY_E;
      9'h02C: idx = KEY_T;
      9'h035: idx = KEY_Y;
      9'h03C: idx = KEY_U;
      9'h175: idx = KEY_UP;
      9'h172: idx = KEY_DOWN;
      9'h16B: idx = KEY_LEFT;
      9'h174: idx = KEY_RIGHT;
      default: idx = -1;
    endcase
    // keys beyond a narrowed key vector read as unmapped
    hit = idx >= 0 && idx < NUM_KEYS;
    index = hit ? IW'(idx) : '0;
  end
endmodule

// File: rtl/keyboard_state_decoder.sv
// keyboard_state_decoder: PS/2 Set-2 byte stream -> held/released key-state vector
// Ports: clk, resetn (async active-low); rx_data/rx_valid = received byte strobe;
// key_state = 1 per held key; key_pressed_pulse = one-cycle pulse on each key press;
// seq_error = one-cycle pulse on a protocol anomaly or prefix timeout.
// Build option: define KBD_PRESS_PULSE_EN to generate key_pressed_pulse, otherwise tied to 0.
module keyboard_state_decoder
  import keyboard_state_decoder_pkg::*;
#(
  parameter int NUM_KEYS = NUM_KEYS_DEFAULT,
  parameter int PREFIX_TIMEOUT = 100000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_pressed_pulse,
  output logic                seq_error
);
  localparam int IW = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1;
  localparam int CW = PREFIX_TIMEOUT > 1 ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PREFIX_TIMEOUT - 1);
  kbd_state_e state_q, state_d;
  logic [NUM_KEYS-1:0] key_state_q, key_state_d;
  logic seq_error_q, seq_error_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic hit;
  logic [IW-1:0] index;
  keyboard_state_decoder_scancode_lut #(.NUM_KEYS(NUM_KEYS)) u_lut (
    .key  ({state_q == ST_EXT || state_q == ST_EXT_BRK, rx_data}),
    .hit  (hit),
    .index(index)
  );
  always_comb begin
    state_d = state_q;
    key_state_d = key_state_q;
    seq_error_d = 1'b0;
    cnt_d = cnt_q;
    if (rx_valid) begin
      // a byte always wins over a timeout expiring in the same cycle
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SC_E0) state_d = ST_EXT;
          else if (rx_data == SC_F0) state_d = ST_BRK;
          else if (is_clear_code(rx_data)) begin
            key_state_d = '0;
            seq_error_d = rx_data != SC_AA;
          end
          else if (rx_data == SC_E1) seq_error_d = 1'b1;
          else if (rx_data != SC_FA && rx_data != SC_FE && hit) key_state_d[index] = 1'b1;
        end
        ST_EXT: begin
          if (rx_data == SC_F0) state_d = ST_EXT_BRK;
          else if (rx_data == SC_E0) seq_error_d = 1'b1;
          else begin
            state_d = ST_IDLE;
            if (hit) key_state_d[index] = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          if (rx_data == SC_F0 || rx_data == SC_E0) seq_error_d = 1'b1;
          else if (hit) key_state_d[index] = 1'b0;
        end
      endcase
    end
    else if (state_q != ST_IDLE) begin
      // dangling prefix: drop it but keep the held keys
      if (cnt_q == CNT_LAST) begin
        state_d = ST_IDLE;
        seq_error_d = 1'b1;
        cnt_d = '0;
      end
      else cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      key_state_q <= '0;
      seq_error_q <= 1'b0;
      cnt_q <= '0;
    end
    else begin
      state_q <= state_d;
      key_state_q <= key_state_d;
      seq_error_q <= seq_error_d;
      cnt_q <= cnt_d;
    end
  end
  assign key_state = key_state_q;
  assign seq_error = seq_error_q;
`ifdef KBD_PRESS_PULSE_EN
  logic [NUM_KEYS-1:0] key_pressed_pulse_q, key_pressed_pulse_d;
  // registered alongside key_state so the pulse coincides with the rising bit
  assign key_pressed_pulse_d = key_state_d & ~key_state_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) key_pressed_pulse_q <= '0;
    else key_pressed_pulse_q <= key_pressed_pulse_d;
  end
  assign key_pressed_pulse = key_pressed_pulse_q;
`else
  assign key_pressed_pulse = '0;
`endif
endmodule

// File: tb/tb_keyboard_state_decoder.sv
// tb_keyboard_state_decoder: scoreboard bench with a behavioural keyboard model
module tb_keyboard_state_decoder;
  import keyboard_state_decoder_pkg::*;
  localparam int TO = 20;
  typedef struct {
    logic [31:0] ks;
    logic        err;
    logic [31:0] kp;
  } exp_t;
  logic clk = 0;
  logic resetn = 0;
  logic [7:0] rx_data = 0;
  logic rx_valid = 0;
  logic [31:0] key_state, key_pressed_pulse;
  logic seq_error;
  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  int key_map[int];
  bit m_ext, m_brk;
  int m_idle;
  logic [31:0] m_keys;
  keyboard_state_decoder #(.NUM_KEYS(32), .PREFIX_TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_state(key_state), .key_pressed_pulse(key_pressed_pulse), .seq_error(seq_error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  function automatic void model_reset();
    m_ext = 0; m_brk = 0; m_idle = 0; m_keys = '0;
  endfunction
  // one cycle of keyboard protocol semantics: what a byte (or its absence) means
  function automatic exp_t model_step(input bit v, input logic [7:0] d);
    exp_t e;
    logic [31:0] prev = m_keys;
    int k;
    e.err = 0;
    if (v) begin
      m_idle = 0;
      k = d;
      if (m_ext) k += 256;
      if (!m_ext && !m_brk) begin
        if (d == 8'hE0) m_ext = 1;
        else if (d == 8'hF0) m_brk = 1;
        else if (d == 8'hE1) e.err = 1;
        else if (d == 8'hAA) m_keys = '0;
        else if (d == 8'hFC || d == 8'h00 || d == 8'hFF) begin m_keys = '0; e.err = 1; end
        else if (d != 8'hFA && d != 8'hFE && key_map.exists(k)) m_keys[key_map[k]] = 1;
      end
      else if (m_brk) begin
        if (d == 8'hF0 || d == 8'hE0) e.err = 1;
        else if (key_map.exists(k)) m_keys[key_map[k]] = 0;
        m_ext = 0; m_brk = 0;
      end
      else begin
        if (d == 8'hF0) m_brk = 1;
        else if (d == 8'hE0) e.err = 1;
        else begin
          if (key_map.exists(k)) m_keys[key_map[k]] = 1;
          m_ext = 0;
        end
      end
    end
    else if (m_ext || m_brk) begin
      m_idle++;
      if (m_idle == TO) begin e.err = 1; m_ext = 0; m_brk = 0; m_idle = 0; end
    end
    e.ks = m_keys;
`ifdef KBD_PRESS_PULSE_EN
    e.kp = m_keys & ~prev;
`else
    e.kp = '0;
`endif
    return e;
  endfunction
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    rx_valid = 1; rx_data = d;
    q.push_back(model_step(1, d));
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 0; rx_data = 8'($urandom);
      q.push_back(model_step(0, 8'h00));
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    resetn = 0; rx_valid = 0;
    q.delete();
    model_reset();
    #1;
    chk("reset_key_state", key_state, 0);
    chk("reset_pulse", key_pressed_pulse, 0);
    chk("reset_seq_error", 32'(seq_error), 0);
    @(negedge clk);
    resetn = 1;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (resetn && q.size() > 0) begin
        e = q.pop_front();
        chk("key_state", key_state, e.ks);
        chk("seq_error", 32'(seq_error), 32'(e.err));
        chk("key_pressed_pulse", key_pressed_pulse, e.kp);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] codes[20] = '{8'h29, 8'h5A, 8'h2D, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B,
                              8'h42, 8'h1D, 8'h24, 8'h2C, 8'h35, 8'h3C, 8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] ctrl[6] = '{8'hAA, 8'hFC, 8'hFA, 8'hFE, 8'h00, 8'hFF};
    int ext_idx[4] = '{KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT};
    int base_idx[16] = '{KEY_SPACE, KEY_ENTER, KEY_R, KEY_A, KEY_S, KEY_D, KEY_F, KEY_G,
                         KEY_H, KEY_J, KEY_K, KEY_W, KEY_E, KEY_T, KEY_Y, KEY_U};
    for (int i = 0; i < 16; i++) key_map[int'(codes[i])] = base_idx[i];
    for (int i = 0; i < 4; i++) key_map[256 + int'(codes[16 + i])] = ext_idx[i];
    do_reset();
    send(8'h29); idle(5); send(8'hF0); send(8'h29); idle(5);
    send(8'hE0); send(8'h75); idle(2); send(8'hE0); send(8'hF0); send(8'h75); idle(2);
    send(8'h75); idle(2);
    for (int i = 0; i < 4; i++) begin send(8'h1C); idle(1); end
    send(8'hF0); send(8'h1C); idle(2);
    send(8'hF0); idle(TO); send(8'h1C); idle(2); send(8'hF0); send(8'h1C); idle(1);
    send(8'hE0); idle(TO - 1); send(8'h72); idle(1);
    send(8'h29); send(8'h5A); send(8'hAA); idle(2);
    send(8'h29); send(8'hFC); idle(2);
    send(8'hE1); send(8'h29); idle(1); send(8'hE0); send(8'hE0); send(8'h6B); idle(1);
    send(8'hE0); send(8'hF0); do_reset(); send(8'h75); idle(2);
    for (int n = 0; n < 2000; n++) begin
      int r = $urandom_range(0, 31);
      int g = $urandom_range(0, 99);
      if (r < 4) send(8'hE0);
      else if (r < 8) send(8'hF0);
      else if (r < 26) send(codes[$urandom_range(0, 19)]);
      else if (r == 26) send(8'hE1);
      else if (r == 27) send(ctrl[$urandom_range(0, 5)]);
      else send(8'($urandom));
      if (g >= 60 && g < 90) idle($urandom_range(1, 3));
      else if (g >= 90 && g < 95) idle(TO - 1);
      else if (g >= 95) idle(TO + $urandom_range(0, 2));
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    idle(1);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
